// File: rtl/fp16_pkg.sv
// fp16_pkg: shared fp16 constants and accumulator FSM state type.
// Used by fp16_accumulator and fp16_lzc.
package fp16_pkg;

    localparam int          FP16_BIAS    = 15;
    localparam logic [15:0] FP16_PINF    = 16'h7C00;
    localparam logic [15:0] FP16_NINF    = 16'hFC00;
    localparam logic [15:0] FP16_NAN     = 16'h7C01;
    localparam logic [15:0] FP16_MAXNORM = 16'h7BFF;

    typedef enum logic [1:0] {
        ACC,
        ALIGN,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp16_lzc.sv
// fp16_lzc: 15-bit leading-zero counter for post-add normalization.
// An all-zero input returns 15.
module fp16_lzc
    import fp16_pkg::*;
(
    input  logic [14:0] d,
    output logic [3:0]  cnt
);

    // Highest set bit wins; scan upward so the last hit is the MSB.
    always_comb begin
        cnt = 4'd15;
        for (int i = 0; i < 15; i++) begin
            if (d[i]) cnt = 4'(14 - i);
        end
    end

endmodule

// File: rtl/fp16_accumulator.sv
// fp16_accumulator: 3-cycle RNE fp16 accumulate of LEN products.
// Macro FP16_ACC_SATURATE_EN: finite overflow saturates to max-normal.
module fp16_accumulator
    import fp16_pkg::*;
#(
    parameter int LEN = 4
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        clr,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_inc;
    logic [15:0] acc, opnd;

    logic        al_sign, al_sub, al_spec;
    logic [4:0]  al_exp;
    logic [13:0] al_big, al_small;
    logic [15:0] al_spec_val;

    logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
    logic [14:0] a_mag, b_mag, big_mag, sml_mag;
    logic [4:0]  shamt;
    logic [13:0] sml_ext, sml_sh;
    logic [27:0] sh_full;
    logic        spec;
    logic [15:0] spec_val;

    logic [14:0]       sum;
    logic [3:0]        lz, lsh;
    logic [13:0]       nrm;
    logic              rnd;
    logic [11:0]       mant_r;
    logic [9:0]        frac;
    logic signed [6:0] e_n, e_f;
    logic [15:0]       ovf, res;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign cnt_inc   = cnt + 8'd1;

    // ALIGN: classify, order by magnitude, shift the smaller operand.
    assign a_zero = (acc[14:10] == 5'd0);
    assign b_zero = (opnd[14:10] == 5'd0);
    assign a_inf  = (acc[14:10] == 5'h1F) && (acc[9:0] == 10'd0);
    assign b_inf  = (opnd[14:10] == 5'h1F) && (opnd[9:0] == 10'd0);
    assign a_nan  = (acc[14:10] == 5'h1F) && (acc[9:0] != 10'd0);
    assign b_nan  = (opnd[14:10] == 5'h1F) && (opnd[9:0] != 10'd0);
    assign a_mag  = a_zero ? 15'd0 : acc[14:0];
    assign b_mag  = b_zero ? 15'd0 : opnd[14:0];
    assign swap    = (b_mag > a_mag);
    assign big_mag = swap ? b_mag : a_mag;
    assign sml_mag = swap ? a_mag : b_mag;
    assign shamt   = big_mag[14:10] - sml_mag[14:10];
    assign sml_ext = {sml_mag != 15'd0, sml_mag[9:0], 3'b000};
    assign sh_full = {sml_ext, 14'd0} >> shamt;
    assign sml_sh  = (shamt >= 5'd14) ? {13'd0, |sml_ext}
                   : {sh_full[27:15], sh_full[14] | (|sh_full[13:0])};

    // NaN/Inf operands bypass the arithmetic path.
    always_comb begin
        spec     = 1'b1;
        spec_val = FP16_NAN;
        if (a_nan || b_nan)
            spec_val = FP16_NAN;
        else if (a_inf && b_inf && (acc[15] ^ opnd[15]))
            spec_val = FP16_NAN;
        else if (a_inf)
            spec_val = acc;
        else if (b_inf)
            spec_val = opnd;
        else
            spec = 1'b0;
    end

    // NORM: add/sub, normalize, round to nearest even.
    assign sum = al_sub ? ({1'b0, al_big} - {1'b0, al_small})
                        : ({1'b0, al_big} + {1'b0, al_small});

    fp16_lzc u_lzc (
        .d   (sum),
        .cnt (lz)
    );

    assign lsh    = lz - 4'd1;
    assign nrm    = (lz == 4'd0) ? {sum[14:2], sum[1] | sum[0]}
                                 : (sum[13:0] << lsh);
    assign rnd    = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    assign mant_r = {1'b0, nrm[13:3]} + {11'd0, rnd};
    assign frac   = mant_r[11] ? mant_r[10:1] : mant_r[9:0];
    assign e_n    = $signed({2'b00, al_exp}) + 7'sd1
                  - $signed({3'b000, lz});
    assign e_f    = e_n + $signed({6'd0, mant_r[11]});

`ifdef FP16_ACC_SATURATE_EN
    assign ovf = al_sign ? {1'b1, FP16_MAXNORM[14:0]} : FP16_MAXNORM;
`else
    assign ovf = al_sign ? FP16_NINF : FP16_PINF;
`endif

    // Pick special, flushed-zero, overflow or normal result.
    always_comb begin
        res = {al_sign, e_f[4:0], frac};
        if (al_spec)
            res = al_spec_val;
        else if ((sum == 15'd0) || (e_f <= 7'sd0))
            res = 16'h0000;
        else if (e_f >= 7'sd31)
            res = ovf;
    end

    // State register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= ACC;
        else         state <= state_nx;
    end

    // Next-state decode; clr overrides everything.
    always_comb begin
        state_nx = state;
        unique case (state)
            ACC:   if (in_valid) state_nx = ALIGN;
            ALIGN: state_nx = NORM;
            NORM:  state_nx = (cnt_inc == 8'(LEN)) ? DONE : ACC;
            DONE:  if (out_ready) state_nx = ACC;
        endcase
        if (clr) state_nx = ACC;
    end

    // Operand capture, alignment pipeline and accumulator update.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            acc         <= 16'h0000;
            opnd        <= 16'h0000;
            cnt         <= 8'd0;
            al_sign     <= 1'b0;
            al_sub      <= 1'b0;
            al_spec     <= 1'b0;
            al_exp      <= 5'd0;
            al_big      <= 14'd0;
            al_small    <= 14'd0;
            al_spec_val <= 16'h0000;
        end else if (clr) begin
            acc <= 16'h0000;
            cnt <= 8'd0;
        end else begin
            unique case (state)
                ACC: if (in_valid) opnd <= in_data;
                ALIGN: begin
                    al_sign     <= swap ? opnd[15] : acc[15];
                    al_sub      <= acc[15] ^ opnd[15];
                    al_spec     <= spec;
                    al_spec_val <= spec_val;
                    al_exp      <= big_mag[14:10];
                    al_big      <= {big_mag != 15'd0, big_mag[9:0], 3'b000};
                    al_small    <= sml_sh;
                end
                NORM: begin
                    acc <= res;
                    cnt <= cnt_inc;
                end
                DONE: if (out_ready) begin
                    acc <= 16'h0000;
                    cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_accumulator.sv
// tb_fp16_accumulator: directed vectors on LEN=4 and LEN=2 instances.
// Expected sums are hand-computed fp16 values.
module tb_fp16_accumulator;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        iv4 = 1'b0, iv2 = 1'b0;
    logic        out_ready = 1'b0;
    logic        rdy4, rdy2, ov4, ov2;
    logic [15:0] od4, od2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_acc = 0;

    fp16_accumulator #(.LEN(4)) u4 (
        .CLK(CLK), .RESETn(RESETn), .clr(clr),
        .in_data(in_data), .in_valid(iv4), .in_ready(rdy4),
        .out_data(od4), .out_valid(ov4), .out_ready(out_ready)
    );

    fp16_accumulator #(.LEN(2)) u2 (
        .CLK(CLK), .RESETn(RESETn), .clr(clr),
        .in_data(in_data), .in_valid(iv2), .in_ready(rdy2),
        .out_data(od2), .out_valid(ov2), .out_ready(out_ready)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [15:0] v);
        int n = 0;
        while (!(sel ? rdy2 : rdy4) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 40) check("rdy_to", {15'd0, sel ? rdy2 : rdy4}, 16'd1);
        in_data = v;
        if (sel) iv2 = 1'b1;
        else     iv4 = 1'b1;
        @(negedge CLK);
        iv2 = 1'b0;
        iv4 = 1'b0;
        last_acc = acc_cyc;
        acc_cyc  = cyc;
    endtask

    task automatic get(input bit sel, input logic [15:0] exp,
                       input string tag);
        int n = 0;
        while (!(sel ? ov2 : ov4) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_v"}, {15'd0, sel ? ov2 : ov4}, 16'd1);
        check(tag, sel ? od2 : od4, exp);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check({tag, "_clr"}, sel ? od2 : od4, 16'h0000);
    endtask

    task automatic vec2(input logic [15:0] a, b, exp, input string tag);
        send(1'b1, a);
        send(1'b1, b);
        get(1'b1, exp, tag);
    endtask

    task automatic vec4(input logic [15:0] a, b, c, d, exp,
                        input string tag);
        send(1'b0, a);
        send(1'b0, b);
        send(1'b0, c);
        send(1'b0, d);
        get(1'b0, exp, tag);
    endtask

    initial begin
        int n;
        #2;
        check("rst_rdy", {15'd0, rdy4}, 16'd1);
        check("rst_ov", {15'd0, ov4}, 16'd0);
        check("rst_od", od4, 16'h0000);
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);

        // four ones with out_ready held high
        out_ready = 1'b1;
        send(1'b0, 16'h3C00);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 16'h3C00);
            check("t1_space", 16'(acc_cyc - last_acc), 16'd3);
        end
        n = 0;
        while (!ov4 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("t1_lat", 16'(cyc - acc_cyc), 16'd2);
        check("t1_sum", od4, 16'h4400);
        check("t1_rdy_lo", {15'd0, rdy4}, 16'd0);
        @(negedge CLK);
        check("t1_pulse", {15'd0, ov4}, 16'd0);
        check("t1_rdy_hi", {15'd0, rdy4}, 16'd1);
        out_ready = 1'b0;

        vec4(16'h3C00, 16'hBC00, 16'h4000, 16'hC000, 16'h0000, "cancel");
        vec4(16'h3C00, 16'h3800, 16'h3400, 16'hB000, 16'h3E80, "mixed");
        vec4(16'h7E00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h7C01, "nan_stk");

        vec2(16'h3C00, 16'h1000, 16'h3C00, "tie_even");
        vec2(16'h3C01, 16'h1000, 16'h3C02, "tie_odd");
`ifdef FP16_ACC_SATURATE_EN
        vec2(16'h7BFF, 16'h7BFF, 16'h7BFF, "ovf");
        vec2(16'hFBFF, 16'hFBFF, 16'hFBFF, "novf");
`else
        vec2(16'h7BFF, 16'h7BFF, 16'h7C00, "ovf");
        vec2(16'hFBFF, 16'hFBFF, 16'hFC00, "novf");
`endif
        vec2(16'h7C00, 16'hFC00, 16'h7C01, "inf_inf");
        vec2(16'h7C00, 16'h3C00, 16'h7C00, "inf_fin");
        vec2(16'h3C00, 16'hBBFF, 16'h1000, "sub_norm");
        vec2(16'h0401, 16'h8400, 16'h0000, "flush");
        vec2(16'h3C00, 16'h0200, 16'h3C00, "subn_in");

        // clr while the first product is in NORM
        send(1'b0, 16'h3C00);
        @(negedge CLK);
        clr = 1'b1;
        @(negedge CLK);
        clr = 1'b0;
        check("clr_od", od4, 16'h0000);
        check("clr_rdy", {15'd0, rdy4}, 16'd1);
        vec4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4400, "post_clr");

        // stall in DONE
        send(1'b1, 16'h3C00);
        send(1'b1, 16'h3C00);
        @(negedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            check("hold_ov", {15'd0, ov2}, 16'd1);
            check("hold_od", od2, 16'h4000);
            check("hold_rdy", {15'd0, rdy2}, 16'd0);
            @(negedge CLK);
        end
        get(1'b1, 16'h4000, "hold_end");

        // asynchronous reset mid-vector
        send(1'b0, 16'h3C00);
        send(1'b0, 16'h3C00);
        #1;
        RESETn = 1'b0;
        #1;
        check("arst_od", od4, 16'h0000);
        check("arst_rdy", {15'd0, rdy4}, 16'd1);
        check("arst_ov", {15'd0, ov4}, 16'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        vec2(16'h4000, 16'h4000, 16'h4400, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
